// File: rtl/demux3_pkg.sv
// Shared defaults, lane-count helper and mode encoding for the demux3 block.
package demux3_pkg;

  localparam int DEF_WLOG   = 3;
  localparam int DEF_WWIDTH = 8;

  typedef enum logic {
    MODE_DIR = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic int lane_count(input int wlog);
    return 1 << wlog;
  endfunction

endpackage

// File: rtl/demux3_lane.sv
// One demux3 output lane: a single-entry holding register with valid/ready.
module demux3_lane #(
  parameter int WWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [WWIDTH-1:0] din,
  input  logic              out_ready,
  output logic [WWIDTH-1:0] dout,
  output logic              valid,
  output logic              can_accept
);

  logic [WWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A fill on the same edge as a drain wins, so a lane can stream at full rate.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (fill) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = data_q;
  assign valid      = valid_q;
  assign can_accept = !valid_q || out_ready;

endmodule

// File: rtl/demux3.sv
// Registered 1-to-N demultiplexer with directed or round-robin lane choice.
// Optional DEMUX3_NEG_EN adds out_neg, the bitwise inverse of out_data.
module demux3
  import demux3_pkg::*;
#(
  parameter  int WLOG   = DEF_WLOG,
  parameter  int WWIDTH = DEF_WWIDTH,
  localparam int N      = lane_count(WLOG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WWIDTH-1:0]         in_data,
  input  logic [WLOG-1:0]           in_sel,
  input  logic                      in_rr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N-1:0][WWIDTH-1:0]  out_data,
  output logic [N-1:0]              out_valid,
  input  logic [N-1:0]              out_ready,
  output logic [WLOG-1:0]           rr_ptr
`ifdef DEMUX3_NEG_EN
  ,
  output logic [N-1:0][WWIDTH-1:0]  out_neg
`endif
);

  mode_e           mode;
  logic [WLOG-1:0] tgt;
  logic [N-1:0]    can_accept;
  logic [N-1:0]    fill;
  logic            accept;
  logic [WLOG-1:0] rr_ptr_q, rr_ptr_d;

  assign mode     = mode_e'(in_rr);
  assign tgt      = (mode == MODE_RR) ? rr_ptr_q : in_sel;
  assign in_ready = !rst && can_accept[tgt];
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign fill[gi] = accept && (tgt == WLOG'(gi));

      demux3_lane #(
        .WWIDTH(WWIDTH)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill[gi]),
        .din       (in_data),
        .out_ready (out_ready[gi]),
        .dout      (out_data[gi]),
        .valid     (out_valid[gi]),
        .can_accept(can_accept[gi])
      );
    end
  endgenerate

  // The pointer wraps naturally at N because it is exactly WLOG bits wide.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode == MODE_RR)) rr_ptr_d = rr_ptr_q + WLOG'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

`ifdef DEMUX3_NEG_EN
  assign out_neg = ~out_data;
`endif

endmodule
